// File: rtl/y86_imem_loader_pkg.sv
// Shared definitions for the Y86 instruction-memory loader: loader states, fetch window size,
// core status codes. Optional checksum stage selected by Y86_LOADER_CHECKSUM_EN.
package y86_imem_loader_pkg;

  localparam int unsigned IMEM_FETCH_BYTES = 10;

  localparam logic [1:0] STAT_HALT    = 2'd0;
  localparam logic [1:0] STAT_MEM_ERR = 2'd1;
  localparam logic [1:0] STAT_INS_ERR = 2'd2;

  localparam logic [3:0] ICODE_HALT = 4'h0;

  typedef enum logic [2:0] {
    StLenLo,
    StLenHi,
    StPayload,
    StCheck,
    StRun,
    StErr
  } loader_state_e;

endpackage

// File: rtl/y86_imem_loader_if.sv
// Host byte stream plus core fetch port of the instruction-memory loader.
// master = host/core side, slave = loader.
interface y86_imem_loader_if;
  import y86_imem_loader_pkg::*;

  logic                            in_valid;
  logic [7:0]                      in_data;
  logic                            in_ready;
  logic                            core_run;
  logic                            load_err;
  logic [15:0]                     bytes_loaded;
  logic [63:0]                     f_addr;
  logic [8*IMEM_FETCH_BYTES-1:0]   f_bytes;
  logic                            f_imem_err;

  modport master (
    output in_valid, in_data, f_addr,
    input  in_ready, core_run, load_err, bytes_loaded, f_bytes, f_imem_err
  );

  modport slave (
    input  in_valid, in_data, f_addr,
    output in_ready, core_run, load_err, bytes_loaded, f_bytes, f_imem_err
  );

endinterface

// File: rtl/y86_imem_ram.sv
// Byte RAM for instruction memory: one synchronous write port and a combinational
// multi-byte read window; bytes at or beyond rlen_i read as zero (halt).
module y86_imem_ram #(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned FETCH_BYTES = 10
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [ADDR_W-1:0]          waddr_i,
  input  logic [7:0]                 wdata_i,
  input  logic [ADDR_W-1:0]          raddr_i,
  input  logic [15:0]                rlen_i,
  output logic [8*FETCH_BYTES-1:0]   rdata_o
);

  logic [7:0]  mem [MEM_BYTES];
  logic [16:0] rd_a;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Only bytes written during the current load are visible; stale contents never leak out.
  always_comb begin
    rdata_o = '0;
    rd_a    = '0;
    for (int unsigned i = 0; i < FETCH_BYTES; i++) begin
      rd_a = {{(17 - ADDR_W){1'b0}}, raddr_i} + 17'(i);
      if (rd_a < {1'b0, rlen_i}) begin
        rdata_o[8*i +: 8] = mem[rd_a[ADDR_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/y86_imem_loader.sv
// Y86 instruction-memory loader: length-prefixed byte stream fills the RAM, then releases the
// core and serves its 10-byte fetch window. Y86_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module y86_imem_loader
  import y86_imem_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input logic               clk,
  input logic               rst_n,
  y86_imem_loader_if.slave  bus
);

`ifdef Y86_LOADER_CHECKSUM_EN
  localparam loader_state_e StAfterPayload = StCheck;
`else
  localparam loader_state_e StAfterPayload = StRun;
`endif

  loader_state_e state_q, state_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          rdy_en_q;
  logic          hs;
  logic          we;
  logic [15:0]   len_full;
  logic [64:0]   f_end;
  logic          f_err;
  logic [8*IMEM_FETCH_BYTES-1:0] ram_rdata;
`ifdef Y86_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    sum_final;
`endif

  assign hs       = bus.in_valid && bus.in_ready;
  assign len_full = {bus.in_data, len_lo_q};

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    we       = 1'b0;
`ifdef Y86_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    sum_final = sum_q + bus.in_data;
`endif
    unique case (state_q)
      StLenLo: begin
        if (hs) begin
          len_lo_d = bus.in_data;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (hs) begin
          len_d = len_full;
          if (32'(len_full) > MEM_BYTES) begin
            state_d = StErr;
          end else if (len_full == 16'd0) begin
            state_d = StAfterPayload;
          end else begin
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (hs) begin
          we    = 1'b1;
          cnt_d = cnt_q + 16'd1;
`ifdef Y86_LOADER_CHECKSUM_EN
          sum_d = sum_final;
`endif
          if (cnt_q == len_q - 16'd1) begin
            state_d = StAfterPayload;
          end
        end
      end
      StCheck: begin
`ifdef Y86_LOADER_CHECKSUM_EN
        if (hs) begin
          state_d = (sum_final == 8'h00) ? StRun : StErr;
        end
`else
        state_d = StErr;
`endif
      end
      StRun:   state_d = StRun;
      StErr:   state_d = StErr;
      default: state_d = StErr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StLenLo;
      len_lo_q <= 8'h00;
      len_q    <= 16'd0;
      cnt_q    <= 16'd0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

`ifdef Y86_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  // rdy_en_q keeps in_ready low while reset is asserted.
  assign bus.in_ready     = rdy_en_q &&
                            (state_q inside {StLenLo, StLenHi, StPayload, StCheck});
  assign bus.core_run     = (state_q == StRun);
  assign bus.load_err     = (state_q == StErr);
  assign bus.bytes_loaded = cnt_q;

  // 65-bit sum so a PC near 2**64 cannot wrap back into range.
  assign f_end          = {1'b0, bus.f_addr} + 65'd9;
  assign f_err          = (f_end >= 65'(MEM_BYTES));
  assign bus.f_imem_err = f_err;
  assign bus.f_bytes    = f_err ? '0 : ram_rdata;

  y86_imem_ram #(
    .MEM_BYTES   (MEM_BYTES),
    .ADDR_W      (ADDR_W),
    .FETCH_BYTES (IMEM_FETCH_BYTES)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (cnt_q[ADDR_W-1:0]),
    .wdata_i (bus.in_data),
    .raddr_i (bus.f_addr[ADDR_W-1:0]),
    .rlen_i  (cnt_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_y86_imem_loader.sv
// Directed bench for y86_imem_loader: fetch expectations come from a byte model queued as a
// scoreboard. Honours Y86_LOADER_CHECKSUM_EN by appending the checksum byte to each load.
module tb_y86_imem_loader;
  import y86_imem_loader_pkg::*;

  localparam int unsigned MEM_BYTES = 1024;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  y86_imem_loader_if bus ();

  y86_imem_loader #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0]  model_mem [MEM_BYTES];
  int          model_cnt = 0;
  logic [80:0] exp_q[$];

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [80:0] model_fetch(input logic [63:0] a);
    logic        err;
    logic [79:0] b;
    logic [63:0] ai;
    err = (({1'b0, a} + 65'd9) >= 65'(MEM_BYTES));
    b   = '0;
    if (!err) begin
      for (int i = 0; i < 10; i++) begin
        ai = a + 64'(i);
        if (ai < 64'(model_cnt)) b[8*i +: 8] = model_mem[int'(ai)];
      end
    end
    return {err, b};
  endfunction

  task automatic fetch(input string tag, input logic [63:0] a);
    logic [80:0] e;
    bus.f_addr = a;
    exp_q.push_back(model_fetch(a));
    #1;
    e = exp_q.pop_front();
    chk({tag, "_bytes"}, bus.f_bytes, e[79:0]);
    chk({tag, "_err"}, 80'(bus.f_imem_err), 80'(e[80]));
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1;
    chk("rst_ready_low", 80'(bus.in_ready), 80'd0);
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready_high", 80'(bus.in_ready), 80'd1);
    chk("rst_core_run", 80'(bus.core_run), 80'd0);
    chk("rst_load_err", 80'(bus.load_err), 80'd0);
    chk("rst_bytes_loaded", 80'(bus.bytes_loaded), 80'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n            = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 16) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    assert (n < 16)
    else begin
      bad++;
      $error("FAIL hs_timeout got=stalled exp=ready");
    end
    if (n < 16) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic load(input byte_q_t pl, input int gap);
    logic [15:0] len;
    logic [7:0]  s;
    len = 16'(pl.size());
    s   = 8'h00;
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    for (int k = 0; k < pl.size(); k++) begin
      send_byte(pl[k]);
      model_mem[k] = pl[k];
      model_cnt    = k + 1;
      s            = s + pl[k];
      chk("bytes_loaded_step", 80'(bus.bytes_loaded), 80'(model_cnt));
      if (k < pl.size() - 1) chk("core_run_early", 80'(bus.core_run), 80'd0);
      repeat (gap) @(posedge clk);
      #1;
      chk("bytes_loaded_hold", 80'(bus.bytes_loaded), 80'(model_cnt));
    end
`ifdef Y86_LOADER_CHECKSUM_EN
    send_byte(8'h00 - s);
`endif
    chk("load_core_run", 80'(bus.core_run), 80'd1);
    chk("load_ready_low", 80'(bus.in_ready), 80'd0);
  endtask

  initial begin
    byte_q_t p;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.f_addr   = 64'd0;

    // Basic 2-byte program
    do_reset();
    fetch("pre_load", 64'd0);
    p = {8'h10, 8'h00};
    load(p, 0);
    chk("t1_bytes_loaded", 80'(bus.bytes_loaded), 80'd2);
    fetch("t1_f0", 64'd0);

    // Fetch range boundaries
    fetch("t3_1014", 64'd1014);
    fetch("t3_1015", 64'd1015);
    fetch("t3_max", 64'hFFFF_FFFF_FFFF_FFFF);

    // Extra bytes after RUN are back-pressured
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    chk("extra_ready", 80'(bus.in_ready), 80'd0);
    chk("extra_bytes_loaded", 80'(bus.bytes_loaded), 80'd2);
    bus.in_valid = 1'b0;
    fetch("extra_f0", 64'd0);

    // Oversize length -> error
    do_reset();
    send_byte(8'h01);
    send_byte(8'h04);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_load_err", 80'(bus.load_err), 80'd1);
    chk("t2_ready", 80'(bus.in_ready), 80'd0);
    chk("t2_core_run", 80'(bus.core_run), 80'd0);
    fetch("t2_f0", 64'd0);

    // Gapped stream
    do_reset();
    p = {8'hA0, 8'hB0, 8'hC0, 8'hD0};
    load(p, 3);
    chk("t4_low32", 80'(bus.f_bytes[31:0]), 80'(32'hD0C0_B0A0));
    fetch("t4_f0", 64'd0);
    fetch("t4_f2", 64'd2);

    // Reset mid-load, then a fresh load
    do_reset();
    send_byte(8'h0A);
    send_byte(8'h00);
    for (int k = 0; k < 5; k++) send_byte(8'h50 + 8'(k));
    chk("t5_mid_count", 80'(bus.bytes_loaded), 80'd5);
    do_reset();
    fetch("t5_after_rst", 64'd0);
    p = {8'h11, 8'h22, 8'h33};
    load(p, 0);
    fetch("t5_fresh", 64'd0);

    // Zero-length program runs immediately
    do_reset();
    p = {};
    load(p, 0);
    fetch("zero_len_f0", 64'd0);

`ifdef Y86_LOADER_CHECKSUM_EN
    // Bad checksum
    do_reset();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'hF1);
    chk("t6_load_err", 80'(bus.load_err), 80'd1);
    chk("t6_core_run", 80'(bus.core_run), 80'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
